// File: rtl/clock_time_pkg.sv
// Shared types, field limits and the two-digit BCD increment used by the
// hms_time_keeper time-of-day engine.
package clock_time_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        ADJ_HOUR = 2'd1,
        ADJ_MIN  = 2'd2
    } state_t;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    // Returns {wrapped_value[7:0], carry}. Any illegal input collapses to 00
    // without carry so a corrupted field self-heals on its next increment.
    function automatic logic [8:0] bcd2_inc(input logic [7:0] value, input logic [7:0] max);
        logic [3:0] max_t;
        logic [3:0] max_u;
        logic [3:0] t;
        logic [3:0] u;
        logic [8:0] r;
        max_t = 4'(max / 8'd10);
        max_u = 4'(max % 8'd10);
        t = value[7:4];
        u = value[3:0];
        if ((u > 4'd9) || (t > max_t) || ((t == max_t) && (u > max_u))) begin
            r = {8'h00, 1'b0};
        end else if ((t == max_t) && (u == max_u)) begin
            r = {8'h00, 1'b1};
        end else if (u == 4'd9) begin
            r = {t + 4'd1, 4'd0, 1'b0};
        end else begin
            r = {t, u + 4'd1, 1'b0};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd2_mod_counter.sv
// Two-digit BCD modulo-(MAX+1) counter with synchronous clear; carry is
// combinational and asserted only while inc is high at MAX.
module bcd2_mod_counter
    import clock_time_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       carry
);

    logic [7:0] val_r;
    logic [8:0] nxt_s;

    // Next value and wrap flag for the current count.
    always_comb begin
        nxt_s = bcd2_inc(val_r, 8'(MAX));
    end

    assign carry = inc & nxt_s[0];
    assign tens  = val_r[7:4];
    assign units = val_r[3:0];

    // Count register: clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_r <= 8'h00;
        end else if (clr) begin
            val_r <= 8'h00;
        end else if (inc) begin
            val_r <= nxt_s[8:1];
        end else begin
            val_r <= val_r;
        end
    end

endmodule

// File: rtl/hms_time_keeper.sv
// HH:MM:SS BCD time keeper with RUN/ADJ_HOUR/ADJ_MIN adjust FSM and blink.
// Optional build macro ADJ_TIMEOUT_EN: leave adjust mode after ADJ_TIMEOUT_S idle seconds.
module hms_time_keeper
    import clock_time_pkg::*;
#(
    parameter int CLK_FREQ      = 25000000,
    parameter int BLINK_CYCLES  = 12500000,
    parameter int ADJ_TIMEOUT_S = 10
) (
    input  logic        clk_25m,
    input  logic        rst_n_25m,
    input  logic        flag_adjust,
    input  logic        flag_add,
    output logic [23:0] digital_num,
    output logic        h_adjust_en,
    output logic        l_adjust_en,
    output logic        tick_1hz
);

    localparam int PW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
    localparam int BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;

    state_t          state_r;
    state_t          state_s;
    logic [PW-1:0]   presc_r;
    logic [PW-1:0]   presc_s;
    logic [BW-1:0]   blink_cnt_r;
    logic [BW-1:0]   blink_cnt_s;
    logic            phase_r;
    logic            phase_s;
    logic            tick_r;
    logic            h_en_r;
    logic            l_en_r;
    logic            tick_s;
    logic            add_acc_s;
    logic            exit_s;
    logic            timeout_s;
    logic            sec_inc_s;
    logic            min_inc_s;
    logic            hour_inc_s;
    logic            sec_carry_s;
    logic            min_carry_s;
    logic            hour_carry_unused_s;
    logic [3:0]      sec_t_s, sec_u_s, min_t_s, min_u_s, hour_t_s, hour_u_s;

    assign tick_s     = (state_r == RUN) && (presc_r == PW'(CLK_FREQ - 1));
    assign add_acc_s  = flag_add && !flag_adjust && (state_r != RUN);
    assign exit_s     = (state_r != RUN) && (state_s == RUN);
    assign sec_inc_s  = tick_s;
    assign min_inc_s  = ((state_r == RUN) && sec_carry_s) || ((state_r == ADJ_MIN) && add_acc_s);
    assign hour_inc_s = ((state_r == RUN) && min_carry_s) || ((state_r == ADJ_HOUR) && add_acc_s);

    // Next-state logic; flag_adjust outranks the idle timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            RUN: begin
                if (flag_adjust) state_s = ADJ_HOUR;
                else             state_s = RUN;
            end
            ADJ_HOUR: begin
                if (flag_adjust)    state_s = ADJ_MIN;
                else if (timeout_s) state_s = RUN;
                else                state_s = ADJ_HOUR;
            end
            ADJ_MIN: begin
                if (flag_adjust)    state_s = RUN;
                else if (timeout_s) state_s = RUN;
                else                state_s = ADJ_MIN;
            end
            default: state_s = RUN;
        endcase
    end

    // Prescaler counts only while staying in RUN, so an exit restarts a full second.
    always_comb begin
        if ((state_r != RUN) || (state_s != RUN)) begin
            presc_s = '0;
        end else if (tick_s) begin
            presc_s = '0;
        end else begin
            presc_s = presc_r + PW'(1);
        end
    end

    // Blink restarts visible on entry and on every accepted press.
    always_comb begin
        if (state_s == RUN) begin
            blink_cnt_s = '0;
            phase_s     = 1'b0;
        end else if ((state_s != state_r) || add_acc_s) begin
            blink_cnt_s = '0;
            phase_s     = 1'b0;
        end else if (blink_cnt_r == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt_s = '0;
            phase_s     = !phase_r;
        end else begin
            blink_cnt_s = blink_cnt_r + BW'(1);
            phase_s     = phase_r;
        end
    end

    // State, prescaler, blink and registered output flags.
    always_ff @(posedge clk_25m or negedge rst_n_25m) begin
        if (!rst_n_25m) begin
            state_r     <= RUN;
            presc_r     <= '0;
            blink_cnt_r <= '0;
            phase_r     <= 1'b0;
            tick_r      <= 1'b0;
            h_en_r      <= 1'b0;
            l_en_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            presc_r     <= presc_s;
            blink_cnt_r <= blink_cnt_s;
            phase_r     <= phase_s;
            tick_r      <= tick_s;
            h_en_r      <= (state_s == ADJ_HOUR) && phase_s;
            l_en_r      <= (state_s == ADJ_MIN) && phase_s;
        end
    end

`ifdef ADJ_TIMEOUT_EN
    localparam int TW = $clog2(ADJ_TIMEOUT_S + 1);

    logic [PW-1:0] idle_div_r;
    logic [TW-1:0] idle_sec_r;

    assign timeout_s = (state_r != RUN) && !flag_adjust && !flag_add &&
                       (idle_div_r == PW'(CLK_FREQ - 1)) &&
                       (idle_sec_r == TW'(ADJ_TIMEOUT_S - 1));

    // Idle seconds in adjust mode, on a divider independent of the frozen prescaler.
    always_ff @(posedge clk_25m or negedge rst_n_25m) begin
        if (!rst_n_25m) begin
            idle_div_r <= '0;
            idle_sec_r <= '0;
        end else if ((state_r == RUN) || flag_adjust || flag_add) begin
            idle_div_r <= '0;
            idle_sec_r <= '0;
        end else if (idle_div_r == PW'(CLK_FREQ - 1)) begin
            idle_div_r <= '0;
            idle_sec_r <= idle_sec_r + TW'(1);
        end else begin
            idle_div_r <= idle_div_r + PW'(1);
            idle_sec_r <= idle_sec_r;
        end
    end
`else
    logic timeout_cfg_unused_s;

    assign timeout_cfg_unused_s = (ADJ_TIMEOUT_S > 0);
    assign timeout_s            = 1'b0;
`endif

    bcd2_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk   (clk_25m),
        .rst_n (rst_n_25m),
        .clr   (exit_s),
        .inc   (sec_inc_s),
        .tens  (sec_t_s),
        .units (sec_u_s),
        .carry (sec_carry_s)
    );

    bcd2_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk   (clk_25m),
        .rst_n (rst_n_25m),
        .clr   (1'b0),
        .inc   (min_inc_s),
        .tens  (min_t_s),
        .units (min_u_s),
        .carry (min_carry_s)
    );

    bcd2_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk   (clk_25m),
        .rst_n (rst_n_25m),
        .clr   (1'b0),
        .inc   (hour_inc_s),
        .tens  (hour_t_s),
        .units (hour_u_s),
        .carry (hour_carry_unused_s)
    );

    assign digital_num = {hour_t_s, hour_u_s, min_t_s, min_u_s, sec_t_s, sec_u_s};
    assign h_adjust_en = h_en_r;
    assign l_adjust_en = l_en_r;
    assign tick_1hz    = tick_r;

endmodule

// File: tb/tb_hms_time_keeper.sv
// Directed plus randomized bench for hms_time_keeper against a seconds-of-day
// reference model; honours ADJ_TIMEOUT_EN the same way the design does.
module tb_hms_time_keeper;

    localparam int CF = 10;
    localparam int BC = 4;
    localparam int TO = 2;

    logic        clk_25m = 1'b0;
    logic        rst_n_25m = 1'b0;
    logic        flag_adjust = 1'b0;
    logic        flag_add = 1'b0;
    logic [23:0] digital_num;
    logic        h_adjust_en;
    logic        l_adjust_en;
    logic        tick_1hz;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: time as seconds of day, mode 0=RUN 1=ADJ_HOUR 2=ADJ_MIN
    int total_sec, mode, run_age, blink_age, idle_age;
    bit tick_m;

    always #5 clk_25m = ~clk_25m;

    hms_time_keeper #(
        .CLK_FREQ      (CF),
        .BLINK_CYCLES  (BC),
        .ADJ_TIMEOUT_S (TO)
    ) dut (
        .clk_25m     (clk_25m),
        .rst_n_25m   (rst_n_25m),
        .flag_adjust (flag_adjust),
        .flag_add    (flag_add),
        .digital_num (digital_num),
        .h_adjust_en (h_adjust_en),
        .l_adjust_en (l_adjust_en),
        .tick_1hz    (tick_1hz)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [23:0] exp_digits();
        int h, m, s;
        h = total_sec / 3600;
        m = (total_sec / 60) % 60;
        s = total_sec % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        total_sec = 0; mode = 0; run_age = 0; blink_age = 0; idle_age = 0; tick_m = 1'b0;
    endtask

    task automatic model_exit();
        mode      = 0;
        total_sec = total_sec - (total_sec % 60);
        run_age   = 0;
    endtask

    task automatic model_edge(input bit a, input bit d);
        int h, m;
        tick_m = 1'b0;
        if (mode == 0) begin
            run_age++;
            if (run_age % CF == 0) begin
                tick_m    = 1'b1;
                total_sec = (total_sec + 1) % 86400;
            end
        end
        if (a) begin
            if (mode == 2) begin
                model_exit();
            end else begin
                mode      = mode + 1;
                blink_age = 0;
                idle_age  = 0;
            end
        end else if (mode != 0) begin
            if (d) begin
                h = total_sec / 3600;
                m = (total_sec / 60) % 60;
                if (mode == 1) total_sec = ((h + 1) % 24) * 3600 + total_sec % 3600;
                else           total_sec = h * 3600 + ((m + 1) % 60) * 60 + total_sec % 60;
                blink_age = 0;
                idle_age  = 0;
            end else begin
                blink_age++;
                idle_age++;
`ifdef ADJ_TIMEOUT_EN
                if (idle_age == CF * TO) model_exit();
`endif
            end
        end
    endtask

    task automatic step(input bit a, input bit d);
        flag_adjust = a;
        flag_add    = d;
        @(posedge clk_25m);
        model_edge(a, d);
        #1;
        flag_adjust = 1'b0;
        flag_add    = 1'b0;
        check("digits", 32'(digital_num), 32'(exp_digits()));
        check("tick", 32'(tick_1hz), 32'(tick_m));
        check("h_en", 32'(h_adjust_en), 32'((mode == 1) && ((blink_age / BC) % 2 == 1)));
        check("l_en", 32'(l_adjust_en), 32'((mode == 2) && ((blink_age / BC) % 2 == 1)));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic press_add(input int n);
        repeat (n) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
    endtask

    task automatic tick_gap(input string tag);
        int n;
        n = 0;
        do begin
            step(1'b0, 1'b0);
            n++;
        end while (!tick_1hz && n < 20);
        check(tag, 32'(n), 32'(CF));
    endtask

    initial begin
        int r;
        model_reset();
        #3;
        check("reset_digits", 32'(digital_num), 32'h0);
        check("reset_tick", 32'(tick_1hz), 32'h0);
        check("reset_h_en", 32'(h_adjust_en), 32'h0);
        check("reset_l_en", 32'(l_adjust_en), 32'h0);
        #9;
        rst_n_25m = 1'b1;
        idle(10);
        check("first_tick_time", 32'(digital_num), 32'h000001);

        // preload 12:34:56 then reset asynchronously mid-cycle
        step(1'b1, 1'b0); press_add(12);
        step(1'b1, 1'b0); press_add(34);
        step(1'b1, 1'b0);
        idle(560);
        check("preload_123456", 32'(digital_num), 32'h123456);
        #2;
        rst_n_25m = 1'b0;
        #1;
        model_reset();
        check("async_rst_digits", 32'(digital_num), 32'h0);
        check("async_rst_tick", 32'(tick_1hz), 32'h0);
        check("async_rst_h_en", 32'(h_adjust_en), 32'h0);
        check("async_rst_l_en", 32'(l_adjust_en), 32'h0);
        @(posedge clk_25m);
        @(posedge clk_25m);
        #1;
        rst_n_25m = 1'b1;
        tick_gap("post_rst_tick_gap");
        check("post_rst_time", 32'(digital_num), 32'h000001);

        // hour adjust with blink pattern after each press
        step(1'b1, 1'b0);
        repeat (3) begin
            step(1'b0, 1'b1);
            idle(8);
        end
        check("hour_03", 32'(digital_num[23:16]), 32'h03);
        check("minsec_frozen", 32'(digital_num[15:0]), 32'h0001);

        // minute 59 wraps to 00 without touching the hour, then exit
        step(1'b1, 1'b0);
        press_add(59);
        check("min_59", 32'(digital_num[15:8]), 32'h59);
        step(1'b0, 1'b1);
        check("min_wrap", 32'(digital_num[23:8]), 32'h0300);
        step(1'b1, 1'b0);
        check("exit_sec_clr", 32'(digital_num[7:0]), 32'h00);
        tick_gap("exit_tick_gap");

        // preload 23:59:59 and roll over midnight
        step(1'b1, 1'b0); press_add(20);
        step(1'b1, 1'b0); press_add(59);
        step(1'b1, 1'b0);
        idle(590);
        check("preload_235959", 32'(digital_num), 32'h235959);
        idle(10);
        check("midnight_wrap", 32'(digital_num), 32'h000000);

        // simultaneous strobes: adjust wins
        step(1'b1, 1'b0); press_add(5);
        step(1'b1, 1'b1);
        check("simul_hour", 32'(digital_num[23:16]), 32'h05);
        idle(4);
        check("simul_in_adj_min", 32'(l_adjust_en), 32'h1);
        step(1'b1, 1'b0);

        // idle adjust mode: timeout exit or indefinite stay
        step(1'b1, 1'b0);
`ifdef ADJ_TIMEOUT_EN
        idle(20);
        check("timeout_exit_h_en", 32'(h_adjust_en), 32'h0);
        check("timeout_sec_clr", 32'(digital_num[7:0]), 32'h00);
        tick_gap("timeout_tick_gap");
`else
        idle(100);
        check("still_adj_hour", 32'(h_adjust_en), 32'h1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
`endif

        // randomized strobes
        repeat (2000) begin
            r = $urandom_range(0, 99);
            step(r < 4, (r < 1) || (r >= 50 && r < 70));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
